// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and constants for the delayed memory responder
package mem_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP, RESP} state_t;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } cap_t;
endpackage

// File: rtl/latency_counter.sv
// latency_counter: loadable down-counter with zero flag, shared by both wait phases
module latency_counter
  import mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/delayed_mem_responder.sv
// delayed_mem_responder: word memory behind a req/gnt/rvalid handshake with fixed latencies
module delayed_mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          GNT_WAIT    = 2,
  parameter int          RVALID_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
  localparam state_t AFTER_GNT = RVALID_WAIT == 1 ? RESP : WAIT_RESP;
  state_t state, nxt;
  cap_t cap, now;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic in_range, zero, load, dec;
  logic [CNT_W-1:0] load_val;
  assign off      = addr_i - BASE_ADDR;
  assign in_range = off < SPAN;
  assign idx      = off[AW+1:2];
  assign gnt_o    = rst_n && req_i && ((state == IDLE && GNT_WAIT == 0) || (state == WAIT_GNT && zero));
  assign now      = '{err: !in_range, rdata: (we_i || !in_range) ? '0 : mem[idx]};
  // Counter holds "remaining cycles minus one" so zero marks the last wait cycle
  assign load     = (state == IDLE && req_i && GNT_WAIT != 0) || (gnt_o && RVALID_WAIT > 1);
  assign load_val = gnt_o ? CNT_W'(RVALID_WAIT - 2) : CNT_W'(GNT_WAIT - 1);
  assign dec      = (state == WAIT_GNT || state == WAIT_RESP) && !zero && !load;
  latency_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .dec      (dec),
    .load_val (load_val),
    .zero     (zero)
  );
  always_comb begin
    nxt = state;
    if (state == IDLE && req_i) nxt = GNT_WAIT == 0 ? AFTER_GNT : WAIT_GNT;
    else if (state == WAIT_GNT) nxt = !req_i ? IDLE : zero ? AFTER_GNT : WAIT_GNT;
    else if (state == WAIT_RESP && zero) nxt = RESP;
    else if (state == RESP) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cap      <= '0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      state    <= nxt;
      if (gnt_o) cap <= now;
      rvalid_o <= nxt == RESP;
      err_o    <= nxt == RESP && (gnt_o ? now.err : cap.err);
      if (nxt == RESP) rdata_o <= gnt_o ? now.rdata : cap.rdata;
    end
  // Memory is deliberately left out of reset
  always_ff @(posedge clk)
    if (gnt_o && we_i && in_range)
      for (int b = 0; b < 4; b++)
        if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
endmodule

// File: tb/tb_delayed_mem_responder.sv
// tb_delayed_mem_responder: directed and randomized checks of both latency configurations
module tb_delayed_mem_responder;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int GW = 2;
  localparam int RW = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, we_a = 1'b0, gnt_a, rvalid_a, err_a;
  logic [3:0] be_a = '0;
  logic [31:0] addr_a = '0, wdata_a = '0, rdata_a;
  logic req_b = 1'b0, we_b = 1'b0, gnt_b, rvalid_b, err_b;
  logic [3:0] be_b = '0;
  logic [31:0] addr_b = '0, wdata_b = '0, rdata_b;
  logic [31:0] mm [1024];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  delayed_mem_responder dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .addr_i(addr_a), .we_i(we_a), .be_i(be_a), .wdata_i(wdata_a), .rdata_o(rdata_a), .err_o(err_a)
  );
  delayed_mem_responder #(.GNT_WAIT(0), .RVALID_WAIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .addr_i(addr_b), .we_i(we_b), .be_i(be_b), .wdata_i(wdata_b), .rdata_o(rdata_b), .err_o(err_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask
  function automatic logic in_rng(input logic [31:0] a);
    return (a - BASE) < 32'd4096;
  endfunction
  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input string tag);
    int n;
    int idx;
    logic oor;
    logic [31:0] exp_d;
    oor = !in_rng(a);
    idx = int'((a - BASE) >> 2);
    exp_d = (w || oor) ? 32'h0 : mm[idx];
    @(posedge clk); #1;
    req_a = 1'b1; we_a = w; addr_a = a; be_a = be; wdata_a = d;
    n = 0;
    @(negedge clk);
    while (!gnt_a && n < 40) begin n++; @(negedge clk); end
    chk({tag, " gnt latency"}, 32'(n), 32'(GW));
    if (w && !oor)
      for (int b = 0; b < 4; b++) if (be[b]) mm[idx][8*b +: 8] = d[8*b +: 8];
    @(posedge clk); #1;
    req_a = 1'b0; we_a = $urandom_range(0, 1); wdata_a = $urandom;
    n = 1;
    @(negedge clk);
    while (!rvalid_a && n < 40) begin n++; @(negedge clk); end
    chk({tag, " rvalid latency"}, 32'(n), 32'(RW));
    chk({tag, " err"}, 32'(err_a), 32'(oor));
    chk({tag, " rdata"}, rdata_a, exp_d);
    @(negedge clk);
    chk({tag, " rvalid pulse"}, 32'(rvalid_a), 32'h0);
    chk({tag, " err idle"}, 32'(err_a), 32'h0);
    chk({tag, " rdata hold"}, rdata_a, exp_d);
  endtask
  initial begin
    int seen;
    logic [31:0] a;
    #2;
    chk("reset gnt", 32'(gnt_a), 32'h0);
    chk("reset rvalid", 32'(rvalid_a), 32'h0);
    chk("reset err", 32'(err_a), 32'h0);
    chk("reset rdata", rdata_a, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    txn(1'b1, BASE, 4'b1111, 32'h1234_ABCD, "w base");
    txn(1'b0, BASE, 4'b0000, 32'h0, "r base");
    chk("r base value", rdata_a, 32'h1234_ABCD);
    txn(1'b1, BASE, 4'b0101, 32'hFFFF_FFFF, "w lanes");
    txn(1'b0, BASE, 4'b0000, 32'h0, "r lanes");
    chk("r lanes value", rdata_a, 32'h12FF_ABFF);
    txn(1'b0, 32'h0010_1000, 4'b0000, 32'h0, "r oor");
    txn(1'b1, 32'h0010_1000, 4'b1111, 32'hDEAD_BEEF, "w oor");
    txn(1'b1, BASE, 4'b0000, 32'h5555_5555, "w be0");
    txn(1'b0, BASE, 4'b0000, 32'h0, "r after oor/be0");
    chk("r after oor/be0 value", rdata_a, 32'h12FF_ABFF);
    // request dropped while waiting for grant
    @(posedge clk); #1;
    req_a = 1'b1; we_a = 1'b1; addr_a = BASE; be_a = 4'b1111; wdata_a = 32'h0;
    @(negedge clk);
    @(posedge clk); #1 req_a = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (gnt_a || rvalid_a) seen++; end
    chk("abort no handshake", 32'(seen), 32'h0);
    txn(1'b0, BASE, 4'b0000, 32'h0, "r after abort");
    for (int i = 1; i < 8; i++) txn(1'b1, BASE + 32'(i * 4), 4'b1111, $urandom, "w init");
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 1) a = BASE + 32'h1000 + 32'($urandom_range(0, 255) * 4);
      else a = BASE - 32'($urandom_range(1, 64) * 4);
      txn(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, "rand");
    end
    // reset while a read waits for its response
    @(posedge clk); #1;
    req_a = 1'b1; we_a = 1'b0; addr_a = BASE; be_a = 4'b0000;
    seen = 0;
    @(negedge clk);
    while (!gnt_a && seen < 40) begin seen++; @(negedge clk); end
    chk("rst gnt latency", 32'(seen), 32'(GW));
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst mid gnt", 32'(gnt_a), 32'h0);
    chk("rst mid rvalid", 32'(rvalid_a), 32'h0);
    chk("rst mid err", 32'(err_a), 32'h0);
    chk("rst mid rdata", rdata_a, 32'h0);
    seen = 0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (rvalid_a) seen++; end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (rvalid_a) seen++; end
    chk("rst no rvalid", 32'(seen), 32'h0);
    txn(1'b0, BASE, 4'b0000, 32'h0, "r after rst");
    // zero-wait configuration, back-to-back with req held
    @(posedge clk); #1;
    req_b = 1'b1; we_b = 1'b1; addr_b = BASE + 32'd8; be_b = 4'b1111; wdata_b = 32'hCAFE_F00D;
    @(negedge clk);
    chk("b gnt same cycle", 32'(gnt_b), 32'h1);
    chk("b no rvalid yet", 32'(rvalid_b), 32'h0);
    @(posedge clk); #1 we_b = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("b gnt pattern", 32'(gnt_b), 32'(c % 2 == 0));
      chk("b rvalid pattern", 32'(rvalid_b), 32'(c % 2 == 1));
      chk("b err", 32'(err_b), 32'h0);
      if (c % 2 == 1) chk("b rdata", rdata_b, c == 1 ? 32'h0 : 32'hCAFE_F00D);
    end
    req_b = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/delayed_mem_responder.md
DELAYED_MEM_RESPONDER -- requirements
Module: delayed_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0010_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, power of two, number of 32-bit words stored.
REQ-003 SHALL have parameter GNT_WAIT, default 2, range 0..15, cycles from request seen in IDLE to gnt_o.
REQ-004 SHALL have parameter RVALID_WAIT, default 3, range 1..15, cycles from the gnt_o cycle to rvalid_o.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_i  input  1  request; held high with stable attributes until gnt_o.
REQ-008 SHALL have port gnt_o  output  1  grant; one-cycle pulse accepting the request.
REQ-009 SHALL have port rvalid_o  output  1  response valid; one-cycle pulse, issued for reads and writes.
REQ-010 SHALL have port addr_i  input  32  byte address; bits [1:0] ignored.
REQ-011 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-012 SHALL have port be_i  input  4  byte enables for writes; bit n selects wdata_i[8n+7:8n].
REQ-013 SHALL have port wdata_i  input  32  write data.
REQ-014 SHALL have port rdata_o  output  32  read data, meaningful only while rvalid_o is high.
REQ-015 SHALL have port err_o  output  1  high with rvalid_o when the address was out of range.

Function
REQ-016 SHALL implement states IDLE, WAIT_GNT, WAIT_RESP, RESP; exactly one transaction outstanding.
REQ-017 In IDLE with req_i high and GNT_WAIT=0, gnt_o SHALL be asserted combinationally in that cycle and the state SHALL go to WAIT_RESP (RESP if RVALID_WAIT=1).
REQ-018 In IDLE with req_i high and GNT_WAIT>0, the state SHALL go to WAIT_GNT and load the wait counter with GNT_WAIT-1.
REQ-019 In WAIT_GNT the counter SHALL decrement each cycle; at zero with req_i high, gnt_o SHALL assert for that one cycle, so gnt_o appears exactly GNT_WAIT cycles after req_i was first seen.
REQ-020 If req_i falls in WAIT_GNT (protocol violation), the state SHALL return to IDLE with no memory access and no rvalid_o.
REQ-021 At the gnt_o cycle, addr_i, we_i, be_i and wdata_i SHALL be captured; writes SHALL update memory in that cycle, only in enabled byte lanes.
REQ-022 A request is in range when (addr_i - BASE_ADDR) < DEPTH_WORDS*4, unsigned 32-bit compare; the word index is bits [log2(DEPTH_WORDS)+1:2] of that difference.
REQ-023 Out-of-range requests SHALL be granted normally, SHALL not modify memory, and SHALL respond with rdata_o = 0 and err_o = 1.
REQ-024 rvalid_o SHALL assert exactly RVALID_WAIT cycles after the gnt_o cycle, for one cycle, in state RESP.
REQ-025 Read rdata_o SHALL be the word at the captured index as of the gnt_o cycle; for writes, rdata_o SHALL be 0.
REQ-026 Outside rvalid_o, rdata_o SHALL hold its last value; err_o SHALL be 0.
REQ-027 req_i in WAIT_RESP or RESP SHALL not be granted; RESP SHALL always return to IDLE, so the next gnt_o is no earlier than the cycle after rvalid_o.
REQ-028 be_i = 4'b0000 on a write SHALL complete the handshake without changing memory.

Reset
REQ-029 While rst_n is low: state = IDLE, counter = 0, gnt_o = 0, rvalid_o = 0, err_o = 0, rdata_o = 0, captured request cleared.
REQ-030 Reset asserted mid-transaction SHALL abandon it with no rvalid_o; a write already granted stays committed.
REQ-031 Memory array contents SHALL not be reset.

Structure
REQ-032 State enum and the counter width constant (4 bits) SHALL live in shared package mem_responder_pkg.
REQ-033 The wait counter SHALL be a sub-module latency_counter (load, decrement, zero flag), reused for both wait phases.

Verification
REQ-034 Defaults; write 32'h1234_ABCD, be 4'b1111, to 32'h0010_0000 -> gnt_o 2 cycles after req, rvalid_o 3 cycles after gnt, err_o 0.
REQ-035 Read 32'h0010_0000 after REQ-034 -> rdata_o 32'h1234_ABCD with rvalid_o.
REQ-036 Write 32'hFFFF_FFFF with be 4'b0101 over 32'h1234_ABCD, then read -> 32'h12FF_ABFF.
REQ-037 Read 32'h0010_1000 (DEPTH_WORDS=1024) -> granted, rvalid_o with err_o 1, rdata_o 0; memory unchanged.
REQ-038 GNT_WAIT=0, RVALID_WAIT=1, back-to-back reads with req_i held -> gnt_o same cycle as req; rvalid_o next cycle; next gnt_o one cycle after rvalid_o.
REQ-039 rst_n low during WAIT_RESP of a read -> no rvalid_o; all outputs 0; a following read returns previously written data.
